// File: rtl/dot_product_stream.sv
// Streaming multi-beat dot-product engine: multiply, adder tree, accumulate, with
// valid/ready handshakes on both sides and a global stall driven by output backpressure.
module dot_product_stream #(
    parameter int unsigned DW       = 4,
    parameter int unsigned LANES    = 4,
    parameter int unsigned ACC_BITS = 4,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned OW       = 2 * DW + $clog2(LANES) + ACC_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [LANES*DW-1:0]   i_a,
    input  logic [LANES*DW-1:0]   i_b,
    input  logic                  i_last,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OW-1:0]         o_data,
    output logic [CNT_W-1:0]      o_beats
);

    localparam int unsigned PW = 2 * DW;
    localparam int unsigned SW = PW + $clog2(LANES);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic                  stall;

    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic [LANES*DW-1:0]   s1_a_q;
    logic [LANES*DW-1:0]   s1_b_q;

    logic                  s2_valid_q;
    logic                  s2_last_q;
    logic [LANES*PW-1:0]   s2_prod_q;
    logic [LANES*PW-1:0]   prod_d;

    logic                  s3_valid_q;
    logic                  s3_last_q;
    logic [OW-1:0]         s3_sum_q;
    logic [SW-1:0]         tree_sum;
    logic [OW-1:0]         sum_d;

    logic [OW-1:0]         acc_q;
    logic [OW-1:0]         acc_sum;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;

    logic                  out_valid_q;
    logic [OW-1:0]         out_data_q;
    logic [CNT_W-1:0]      out_beats_q;

    // Whole pipeline freezes while a result waits on the downstream.
    assign stall   = out_valid_q && !i_ready;
    assign o_ready = !stall;

    function automatic logic [PW-1:0] ext_op(input logic [DW-1:0] x);
        ext_op = (SIGNED != 0) ? PW'($signed(x)) : PW'(x);
    endfunction

    function automatic logic [SW-1:0] ext_prod(input logic [PW-1:0] p);
        ext_prod = (SIGNED != 0) ? SW'($signed(p)) : SW'(p);
    endfunction

    always_comb begin
        prod_d = '0;
        for (int n = 0; n < LANES; n++) begin
            prod_d[n*PW +: PW] = ext_op(s1_a_q[n*DW +: DW]) * ext_op(s1_b_q[n*DW +: DW]);
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int n = 0; n < LANES; n++) begin
            tree_sum = tree_sum + ext_prod(s2_prod_q[n*PW +: PW]);
        end
        sum_d = (SIGNED != 0) ? OW'($signed(tree_sum)) : OW'(tree_sum);
    end

    assign acc_sum = acc_q + s3_sum_q;
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_prod_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_sum_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else if (!stall) begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_a_q    <= i_a;
                s1_b_q    <= i_b;
                s1_last_q <= i_last;
            end

            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q <= prod_d;
                s2_last_q <= s1_last_q;
            end

            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_sum_q  <= sum_d;
                s3_last_q <= s2_last_q;
            end

            // Not stalled means any pending result transfers now; only a new last reloads it.
            out_valid_q <= s3_valid_q && s3_last_q;
            if (s3_valid_q) begin
                if (s3_last_q) begin
                    out_data_q  <= acc_sum;
                    out_beats_q <= cnt_inc;
                    acc_q       <= '0;
                    cnt_q       <= '0;
                end else begin
                    acc_q <= acc_sum;
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign o_valid = out_valid_q;
    assign o_data  = out_data_q;
    assign o_beats = out_beats_q;

endmodule

// File: tb/tb_dot_product_stream.sv
// Directed bench for dot_product_stream: default unsigned instance plus a signed
// instance with a 2-bit beat counter, both fed the same stimulus.
module tb_dot_product_stream;

    logic        i_clk;
    logic        i_rstn;
    logic        i_valid;
    logic        i_last;
    logic        i_ready;
    logic [15:0] i_a;
    logic [15:0] i_b;

    logic        o_ready;
    logic        o_valid;
    logic [13:0] o_data;
    logic [7:0]  o_beats;

    logic        s_ready;
    logic        s_valid;
    logic [13:0] s_data;
    logic [1:0]  s_beats;

    int n_tests;
    int n_fail;

    dot_product_stream u_dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_beats (o_beats)
    );

    dot_product_stream #(
        .SIGNED (1),
        .CNT_W  (2)
    ) u_sgn (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_valid (i_valid),
        .o_ready (s_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_last  (i_last),
        .o_valid (s_valid),
        .i_ready (i_ready),
        .o_data  (s_data),
        .o_beats (s_beats)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic last);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_last  = last;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input int bound, output int n);
        n = 0;
        while (!o_valid && n < bound) begin
            tick();
            n++;
        end
        if (!o_valid) check(tag, 32'(o_valid), 32'd1);
    endtask

    int          lat;
    int          sent;
    int          got;
    int          stall_left;
    bit          stall_done;
    logic [13:0] held;
    logic [13:0] exp_q[$];
    logic [13:0] exp_v;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        i_rstn  = 1'b0;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;

        // Reset state
        #2;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_beats", 32'(o_beats), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_rstn = 1'b1;
        tick();

        // Single beat, all 15s: 4*225 = 900, visible after the 4th edge
        drive(16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        tick();
        check("t1_early", 32'(o_valid), 32'd0);
        tick();
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_data",  32'(o_data),  32'd900);
        check("t1_beats", 32'(o_beats), 32'd1);
        tick();
        check("t1_once",  32'(o_valid), 32'd0);

        // Three beats: 10 + 16 + 0 = 26
        i_valid = 1'b1;
        i_a = 16'h4321; i_b = 16'h1111; i_last = 1'b0;
        tick();
        check("t2_nv1", 32'(o_valid), 32'd0);
        i_a = 16'h2222; i_b = 16'h2222;
        tick();
        check("t2_nv2", 32'(o_valid), 32'd0);
        i_a = 16'h0000; i_b = 16'hFFFF; i_last = 1'b1;
        tick();
        check("t2_nv3", 32'(o_valid), 32'd0);
        i_valid = 1'b0;
        wait_result("t2_timeout", 10, lat);
        check("t2_lat",   32'(lat),     32'd3);
        check("t2_data",  32'(o_data),  32'd26);
        check("t2_beats", 32'(o_beats), 32'd3);
        tick();
        check("t2_once",  32'(o_valid), 32'd0);

        // Signed: 4 * (-8 * 7) = -224; unsigned instance sees 4 * 8 * 7 = 224
        drive(16'h8888, 16'h7777, 1'b1);
        wait_result("t3_timeout", 10, lat);
        check("t3_sdata",  32'(s_data),  32'h3F20);
        check("t3_svalid", 32'(s_valid), 32'd1);
        check("t3_sbeats", 32'(s_beats), 32'd1);
        check("t3_udata",  32'(o_data),  32'd224);
        tick();

        // Wrap: 19 * 900 = 17100 mod 16384 = 716; 2-bit counter saturates at 3
        for (int i = 0; i < 19; i++) begin
            i_valid = 1'b1;
            i_a = 16'hFFFF; i_b = 16'hFFFF; i_last = (i == 18);
            tick();
        end
        i_valid = 1'b0;
        wait_result("t4_timeout", 10, lat);
        check("t4_data",   32'(o_data),  32'd716);
        check("t4_beats",  32'(o_beats), 32'd19);
        check("t4_sbeats", 32'(s_beats), 32'd3);
        tick();

        // Backpressure: ten single-beat vectors, sums 4*(k+1); 5-cycle stall after first result
        sent = 0; got = 0; stall_left = 0; stall_done = 0; held = '0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            i_ready = (stall_left == 0);
            i_valid = (sent < 10);
            i_a     = {4{4'(sent + 1)}};
            i_b     = 16'h1111;
            i_last  = 1'b1;
            #1;
            if (!i_ready) begin
                check("bp_ready", 32'(o_ready), 32'd0);
                check("bp_valid", 32'(o_valid), 32'd1);
                if (stall_left == 5) held = o_data;
                else check("bp_hold", 32'(o_data), 32'(held));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_extra", 32'(o_data), 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("bp_data", 32'(o_data), 32'(exp_v));
                end
                got++;
            end
            if (i_valid && o_ready) begin
                exp_q.push_back(14'(4 * (sent + 1)));
                sent++;
            end
            if (stall_left > 0) begin
                stall_left--;
            end else if (o_valid && !stall_done) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("bp_count", 32'(got), 32'd10);
        check("bp_stalled", 32'(stall_done), 32'd1);
        tick();
        check("bp_drain", 32'(o_valid), 32'd0);

        // Reset mid-vector: two non-last beats accumulate, then async reset clears everything
        drive(16'hFFFF, 16'hFFFF, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        tick();
        tick();
        #2;
        i_rstn = 1'b0;
        #1;
        check("rst2_valid", 32'(o_valid), 32'd0);
        check("rst2_data",  32'(o_data),  32'd0);
        check("rst2_beats", 32'(o_beats), 32'd0);
        check("rst2_ready", 32'(o_ready), 32'd1);
        #2;
        i_rstn = 1'b1;
        @(negedge i_clk);
        drive(16'h4321, 16'h1111, 1'b1);
        wait_result("t6_timeout", 10, lat);
        check("t6_data",  32'(o_data),  32'd10);
        check("t6_beats", 32'(o_beats), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_stream.md
Name: dot_product_stream

Overview:
- Parametrised, fully pipelined, streaming dot-product engine. Successor to the fixed 4-lane, 4-bit dot-product block.
- Each accepted beat carries LANES element pairs. Partial sums accumulate across beats until a beat flagged last arrives; one result is then emitted.
- Adds valid/ready handshakes with backpressure, signed mode and multi-beat vectors.
- Sits between an operand-fetch stage and a result FIFO in the datapath.

Parameters:
- DW, 4, element width in bits (a and b elements).
- LANES, 4, element pairs per beat; power of two, >=2.
- ACC_BITS, 4, extra accumulator headroom bits for multi-beat vectors.
- SIGNED, 0, 0 = unsigned operands, 1 = two's-complement operands.
- CNT_W, 8, width of the beat counter output.
- OW, 2*DW+$clog2(LANES)+ACC_BITS, result width (derived; default 14).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_a  in  LANES*DW  packed operand vector A; lane n at bits [n*DW +: DW].
- i_b  in  LANES*DW  packed operand vector B, same packing.
- i_last  in  1  beat is the final beat of the current vector.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  OW  dot product of the whole vector.
- o_beats  out  CNT_W  number of beats in that vector; saturates at 2^CNT_W-1.

Behaviour:
- Reset: one clock, i_clk; reset is asynchronous and active-low on i_rstn. While reset is asserted, every register clears: o_valid=0, o_data=0, o_beats=0, accumulator=0, beat counter=0, all stage valids=0. o_ready=1 during and immediately after reset.
- Accept: a beat transfers on a rising edge where i_valid && o_ready. Output transfers on an edge where o_valid && i_ready.
- Stall: stall = o_valid && !i_ready. o_ready = !stall, combinational. While stalled, every pipeline register and the output hold their values.
- Pipeline:
  - S1: registers operands and last flag.
  - S2: registers LANES products, each 2*DW bits. Products are sign-extended when SIGNED=1, zero-extended otherwise.
  - S3: registers the adder-tree sum, 2*DW+$clog2(LANES) bits, extended to OW.
  - S4: accumulate/output stage.
- Each stage carries a valid bit; bubbles propagate with no data effect.
- S4 action, taken when S3 is valid and there is no stall:
  - Not last: acc <= acc + sum; beat counter increments, saturating.
  - Last: o_data <= acc + sum; o_beats <= counter+1 (saturating); o_valid <= 1; acc <= 0; counter <= 0.
- o_valid clears on an output transfer unless a new last result loads in the same edge. Back-to-back results at one per clock are allowed.
- Latency: a last beat accepted at edge k produces o_valid=1 after edge k+3, assuming no stall. Throughput is one beat per clock.
- A single-beat vector (i_last=1 on its only beat) is legal.
- Arithmetic: all accumulation is modulo 2^OW (wrap, no saturation, no flag). In signed mode o_data is two's complement.
- While o_valid=0, o_data holds its last value.
- Reset mid-vector discards any partial accumulation; the next accepted beat starts a new vector.
- i_a, i_b and i_last are ignored when no transfer occurs.

Test Plan:
- Defaults, single beat: i_a lanes all 15, i_b lanes all 15, i_last=1, i_ready=1 -> o_valid after 4th edge counting acceptance as edge 1; o_data=900, o_beats=1; held valid for 1 cycle.
- Three-beat vector: beats with a=1,2,3,4 and b=1,1,1,1 (sum 10), then a=b=2 (sum 16), then a=0 (sum 0) with last -> single result o_data=26, o_beats=3; no o_valid on non-last beats.
- SIGNED=1: all a lanes=-8 (4'h8), all b lanes=7, last -> o_data=14'h3F20 (-224).
- Wrap: 19 beats of all-15 operands, last on 19th -> o_data=17100 mod 16384=716, o_beats=19.
- Backpressure: stream single-beat vectors each clock, hold i_ready=0 for 5 cycles after the first result -> o_ready=0 throughout the stall; o_data stable; no result lost or duplicated; results emerge in order once i_ready=1.
- Reset mid-operation: accept 2 non-last beats, pulse i_rstn low asynchronously between edges -> all outputs 0 immediately. Then a single-beat vector of sum 10 -> o_data=10, o_beats=1.
